// File: rtl/washer_program_ctrl.sv
// Washing-machine program sequencer: prescaled phase timer, multi-rinse loop,
// four latched programs, pause/resume with context save, registered actuator outputs.
module washer_program_ctrl #(
    parameter int TW         = 8,
    parameter int TICK_DIV   = 50000000,
    parameter int FILL_T     = 30,
    parameter int WASH_T     = 60,
    parameter int RINSE_T    = 40,
    parameter int DRAIN_T    = 20,
    parameter int SPIN_T     = 50,
    parameter int RINSE_REPS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          power,
    input  logic          start,
    input  logic [1:0]    program_selection,
    input  logic          pause_resume,
    output logic          valve_in_cold,
    output logic          valve_in_hot,
    output logic          valve_out,
    output logic          motor,
    output logic [TW-1:0] timer_display,
    output logic          program_done,
    output logic [2:0]    current_state
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(RINSE_REPS + 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_FILL  = 3'b001,
        ST_WASH  = 3'b010,
        ST_DRAIN = 3'b011,
        ST_RINSE = 3'b100,
        ST_SPIN  = 3'b101,
        ST_PAUSE = 3'b110,
        ST_DONE  = 3'b111
    } state_t;

    state_t        state_r, state_next_s, resume_r, resume_next_s;
    logic [1:0]    prog_r, prog_next_s;
    logic [RW-1:0] rinse_r, rinse_next_s;
    logic [TW-1:0] cnt_r, cnt_next_s;
    logic [PW-1:0] presc_r, presc_next_s;
    logic [3:0]    act_r;
    logic          done_r;
    logic          tick_s;

    function automatic logic [TW-1:0] wash_len(input logic [1:0] prog);
        wash_len = TW'(WASH_T * (int'(prog) + 1));
    endfunction

    // Actuator bits {cold, hot, out, motor} for a given state and program.
    function automatic logic [3:0] act_decode(input state_t st, input logic [1:0] prog);
        case (st)
            ST_FILL:  act_decode = (prog == 2'b01 || prog == 2'b10) ? 4'b0100 : 4'b1000;
            ST_WASH:  act_decode = 4'b0001;
            ST_DRAIN: act_decode = 4'b0010;
            ST_RINSE: act_decode = 4'b1001;
            ST_SPIN:  act_decode = 4'b0011;
            default:  act_decode = 4'b0000;
        endcase
    endfunction

    assign tick_s = (presc_r == PW'(TICK_DIV - 1));

    // Next-state, phase counter, prescaler and rinse bookkeeping.
    always_comb begin
        state_next_s  = state_r;
        resume_next_s = resume_r;
        prog_next_s   = prog_r;
        rinse_next_s  = rinse_r;
        cnt_next_s    = cnt_r;
        presc_next_s  = presc_r;
        if (!power) begin
            state_next_s = ST_IDLE;
            cnt_next_s   = {TW{1'b0}};
            presc_next_s = {PW{1'b0}};
            rinse_next_s = {RW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        prog_next_s  = program_selection;
                        presc_next_s = {PW{1'b0}};
                        if (program_selection == 2'b11) begin
                            state_next_s = ST_RINSE;
                            rinse_next_s = RW'(RINSE_REPS - 1);
                            cnt_next_s   = TW'(RINSE_T);
                        end else begin
                            state_next_s = ST_FILL;
                            cnt_next_s   = TW'(FILL_T);
                            if (program_selection == 2'b00) begin
                                rinse_next_s = RW'(1);
                            end else if (program_selection == 2'b10) begin
                                rinse_next_s = RW'(RINSE_REPS + 1);
                            end else begin
                                rinse_next_s = RW'(RINSE_REPS);
                            end
                        end
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_PAUSE: begin
                    if (pause_resume) begin
                        state_next_s = resume_r;
                    end else begin
                        state_next_s = ST_PAUSE;
                    end
                end
                ST_FILL, ST_WASH, ST_DRAIN, ST_RINSE, ST_SPIN: begin
                    presc_next_s = tick_s ? {PW{1'b0}} : presc_r + PW'(1);
                    if (pause_resume) begin
                        // A tick landing on the pause edge is consumed, but the final tick never ends the phase.
                        state_next_s  = ST_PAUSE;
                        resume_next_s = state_r;
                        if (!tick_s) begin
                            presc_next_s = presc_r;
                        end else begin
                            presc_next_s = {PW{1'b0}};
                        end
                        if (tick_s && cnt_r > TW'(1)) begin
                            cnt_next_s = cnt_r - TW'(1);
                        end else begin
                            cnt_next_s = cnt_r;
                        end
                    end else if (tick_s && cnt_r == TW'(1)) begin
                        case (state_r)
                            ST_FILL: begin
                                state_next_s = ST_WASH;
                                cnt_next_s   = wash_len(prog_r);
                            end
                            ST_WASH: begin
                                state_next_s = ST_DRAIN;
                                cnt_next_s   = TW'(DRAIN_T);
                            end
                            ST_DRAIN: begin
                                if (rinse_r != {RW{1'b0}}) begin
                                    state_next_s = ST_RINSE;
                                    rinse_next_s = rinse_r - RW'(1);
                                    cnt_next_s   = TW'(RINSE_T);
                                end else begin
                                    state_next_s = ST_SPIN;
                                    cnt_next_s   = TW'(SPIN_T);
                                end
                            end
                            ST_RINSE: begin
                                state_next_s = ST_DRAIN;
                                cnt_next_s   = TW'(DRAIN_T);
                            end
                            ST_SPIN: begin
                                state_next_s = ST_DONE;
                                cnt_next_s   = {TW{1'b0}};
                            end
                            default: begin
                                state_next_s = ST_IDLE;
                                cnt_next_s   = {TW{1'b0}};
                            end
                        endcase
                    end else if (tick_s) begin
                        cnt_next_s = cnt_r - TW'(1);
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = {TW{1'b0}};
                end
            endcase
        end
    end

    // State, context and registered output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            resume_r <= ST_IDLE;
            prog_r   <= 2'b00;
            rinse_r  <= {RW{1'b0}};
            cnt_r    <= {TW{1'b0}};
            presc_r  <= {PW{1'b0}};
            act_r    <= 4'b0000;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            resume_r <= resume_next_s;
            prog_r   <= prog_next_s;
            rinse_r  <= rinse_next_s;
            cnt_r    <= cnt_next_s;
            presc_r  <= presc_next_s;
            act_r    <= act_decode(state_next_s, prog_next_s);
            done_r   <= (state_next_s == ST_DONE);
        end
    end

    assign {valve_in_cold, valve_in_hot, valve_out, motor} = act_r;
    assign timer_display = cnt_r;
    assign current_state = state_r;
    assign program_done  = done_r;
endmodule

// File: tb/tb_washer_program_ctrl.sv
// Scoreboard bench for washer_program_ctrl: expected phase records are queued at
// start and checked (state, display, actuators, length) as the DUT walks through them.
module tb_washer_program_ctrl;
    localparam int TD = 4, FT = 2, WT = 3, RT = 2, DT = 2, STM = 2, REPS = 2;
    localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_WASH = 3'd2, S_DRAIN = 3'd3,
                           S_RINSE = 3'd4, S_SPIN = 3'd5, S_PAUSE = 3'd6, S_DONE = 3'd7;

    logic clk = 1'b0, rst = 1'b0, power = 1'b1, start = 1'b0, pause_resume = 1'b0;
    logic [1:0] program_selection = 2'b00;
    logic valve_in_cold, valve_in_hot, valve_out, motor, program_done;
    logic [7:0] timer_display;
    logic [2:0] current_state;

    typedef struct {
        logic [2:0] st;
        int         len;
        logic [3:0] act;
        logic [7:0] d;
    } phase_t;
    phase_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    washer_program_ctrl #(
        .TW(8), .TICK_DIV(TD), .FILL_T(FT), .WASH_T(WT), .RINSE_T(RT),
        .DRAIN_T(DT), .SPIN_T(STM), .RINSE_REPS(REPS)
    ) dut (
        .clk(clk), .rst(rst), .power(power), .start(start),
        .program_selection(program_selection), .pause_resume(pause_resume),
        .valve_in_cold(valve_in_cold), .valve_in_hot(valve_in_hot),
        .valve_out(valve_out), .motor(motor), .timer_display(timer_display),
        .program_done(program_done), .current_state(current_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] acts();
        return {valve_in_cold, valve_in_hot, valve_out, motor};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] st, input int len, input logic [3:0] act, input int d);
        phase_t p;
        p.st = st; p.len = len; p.act = act; p.d = 8'(d);
        exp_q.push_back(p);
    endtask

    task automatic push_prog(input int prog, input bit with_spin);
        int reps, w;
        reps = (prog == 0) ? 1 : (prog == 2) ? REPS + 1 : REPS;
        if (prog != 3) begin
            push(S_FILL, FT * TD, (prog == 1 || prog == 2) ? 4'b0100 : 4'b1000, FT);
            w = WT * (prog + 1);
            push(S_WASH, w * TD, 4'b0001, w);
        end else begin
            push(S_RINSE, RT * TD, 4'b1001, RT);
            reps--;
        end
        for (int r = 0; r < reps; r++) begin
            push(S_DRAIN, DT * TD, 4'b0010, DT);
            push(S_RINSE, RT * TD, 4'b1001, RT);
        end
        push(S_DRAIN, DT * TD, 4'b0010, DT);
        if (with_spin) push(S_SPIN, STM * TD, 4'b0011, STM);
    endtask

    task automatic run_phases(output int total);
        phase_t p;
        int n;
        total = 0;
        while (exp_q.size() != 0) begin
            p = exp_q.pop_front();
            check_eq("phase_state", current_state, p.st);
            check_eq("phase_display", timer_display, p.d);
            n = 0;
            do begin
                check_eq("actuators", acts(), p.act);
                step();
                n++;
            end while (current_state == p.st && n < 300);
            check_eq("phase_len", n, p.len);
            total += n;
        end
    endtask

    task automatic do_start(input logic [1:0] prog, input logic with_pause);
        program_selection = prog;
        start = 1'b1;
        pause_resume = with_pause;
        step();
        start = 1'b0;
        pause_resume = 1'b0;
    endtask

    task automatic pulse_pause();
        pause_resume = 1'b1;
        step();
        pause_resume = 1'b0;
    endtask

    task automatic check_done(input string tag);
        check_eq({tag, "_state"}, current_state, S_DONE);
        check_eq({tag, "_done"}, program_done, 1'b1);
        check_eq({tag, "_display"}, timer_display, 8'd0);
        check_eq({tag, "_act"}, acts(), 4'b0000);
    endtask

    initial begin
        int total, n;
        #2;
        check_eq("rst_state", current_state, S_IDLE);
        check_eq("rst_act", acts(), 4'b0000);
        check_eq("rst_display", timer_display, 8'd0);
        check_eq("rst_done", program_done, 1'b0);
        #10 rst = 1'b1;
        step();

        // Quick program.
        push_prog(0, 1'b1);
        do_start(2'b00, 1'b0);
        run_phases(total);
        check_eq("quick_total", total, 52);
        check_done("quick");

        // Heavy program; start with simultaneous pause pulse from DONE takes start.
        push_prog(2, 1'b1);
        do_start(2'b10, 1'b1);
        run_phases(total);
        check_eq("heavy_total", total, 108);
        check_done("heavy");

        // Rinse+spin program.
        push_prog(3, 1'b1);
        do_start(2'b11, 1'b0);
        run_phases(total);
        check_eq("rinse_total", total, 40);
        check_done("rinse");

        // Normal program.
        push_prog(1, 1'b1);
        do_start(2'b01, 1'b0);
        run_phases(total);
        check_eq("normal_total", total, 8 + 24 + 16 * REPS + 8 + 8);
        check_done("normal");

        // Pause in WASH at display 2, hold 100 cycles, resume.
        push(S_FILL, FT * TD, 4'b1000, FT);
        do_start(2'b00, 1'b0);
        run_phases(total);
        check_eq("pz_wash_entry", timer_display, 8'd3);
        repeat (TD) step();
        check_eq("pz_before", timer_display, 8'd2);
        pulse_pause();
        for (int i = 0; i < 100; i++) begin
            check_eq("pz_state", current_state, S_PAUSE);
            check_eq("pz_display", timer_display, 8'd2);
            check_eq("pz_act", acts(), 4'b0000);
            step();
        end
        pulse_pause();
        check_eq("pz_resume_state", current_state, S_WASH);
        check_eq("pz_resume_display", timer_display, 8'd2);
        n = 0;
        while (current_state == S_WASH && n < 100) begin
            step();
            n++;
        end
        check_eq("pz_remaining", n, 2 * TD);
        push(S_DRAIN, DT * TD, 4'b0010, DT);
        push(S_RINSE, RT * TD, 4'b1001, RT);
        push(S_DRAIN, DT * TD, 4'b0010, DT);
        push(S_SPIN, STM * TD, 4'b0011, STM);
        run_phases(total);
        check_done("pz");

        // Pause colliding with SPIN expiry.
        push_prog(0, 1'b0);
        do_start(2'b00, 1'b0);
        run_phases(total);
        check_eq("col_spin", current_state, S_SPIN);
        repeat (2 * TD - 1) step();
        check_eq("col_before", timer_display, 8'd1);
        pulse_pause();
        check_eq("col_state", current_state, S_PAUSE);
        check_eq("col_display", timer_display, 8'd1);
        check_eq("col_act", acts(), 4'b0000);
        repeat (10) step();
        pulse_pause();
        check_eq("col_resume", current_state, S_SPIN);
        n = 0;
        while (current_state == S_SPIN && n < 100) begin
            step();
            n++;
        end
        check_eq("col_to_done", n, TD);
        check_done("col");

        // power=0 during RINSE.
        push(S_FILL, FT * TD, 4'b0100, FT);
        push(S_WASH, 2 * WT * TD, 4'b0001, 2 * WT);
        push(S_DRAIN, DT * TD, 4'b0010, DT);
        do_start(2'b01, 1'b0);
        run_phases(total);
        check_eq("ab_rinse", current_state, S_RINSE);
        check_eq("ab_rinse_act", acts(), 4'b1001);
        repeat (3) step();
        power = 1'b0;
        step();
        check_eq("ab_state", current_state, S_IDLE);
        check_eq("ab_act", acts(), 4'b0000);
        check_eq("ab_display", timer_display, 8'd0);
        check_eq("ab_done", program_done, 1'b0);
        power = 1'b1;
        pulse_pause();
        check_eq("ab_idle_pause", current_state, S_IDLE);

        // start ignored in WASH, then asynchronous reset mid-DRAIN.
        push(S_FILL, FT * TD, 4'b1000, FT);
        do_start(2'b00, 1'b0);
        run_phases(total);
        repeat (2) step();
        do_start(2'b11, 1'b0);
        check_eq("ign_state", current_state, S_WASH);
        check_eq("ign_act", acts(), 4'b0001);
        n = 0;
        while (current_state != S_DRAIN && n < 100) begin
            step();
            n++;
        end
        check_eq("ign_wash_left", n, WT * TD - 3);
        check_eq("rr_drain_act", acts(), 4'b0010);
        step();
        #2 rst = 1'b0;
        #1;
        check_eq("rr_state", current_state, S_IDLE);
        check_eq("rr_act", acts(), 4'b0000);
        check_eq("rr_display", timer_display, 8'd0);
        check_eq("rr_done", program_done, 1'b0);
        #10 rst = 1'b1;
        step();
        check_eq("rr_after", current_state, S_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
